// File: rtl/mem_ctrl_if.sv
// Host-side SRAM request bus: one request per cycle, registered read data back.
interface mem_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] ADDR;
   logic              CE;
   logic              CSB;
   logic              WEB;
   logic              OEB;
   logic [DATA_W-1:0] IDATA;
   logic [DATA_W-1:0] ODATA;

   modport master (
      output ADDR, CE, CSB, WEB, OEB, IDATA,
      input  ODATA
   );

   modport slave (
      input  ADDR, CE, CSB, WEB, OEB, IDATA,
      output ODATA
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide SRAM controller: stage 1 captures the request, stage 2 accesses the
// embedded array. ODATA only changes when a read completes.
module mem_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic     CLK,
   input  logic     RST,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   // The state doubles as the stage-1 valid/type: it names the op stage 2 runs next.
   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_idata;
   logic [DATA_W-1:0] r_odata;
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   logic w_req;
   logic w_wr_req;
   logic w_rd_req;
   logic w_mem_we;
   logic w_mem_re;

   always_comb begin
      w_req        = bus.CE & ~bus.CSB;
      w_wr_req     = w_req & ~bus.WEB;
      w_rd_req     = w_req & bus.WEB & ~bus.OEB;
      w_state_next = IDLE;
      w_mem_we     = 1'b0;
      w_mem_re     = 1'b0;
      case (r_state)
         WRITE:   w_mem_we = 1'b1;
         READ:    w_mem_re = 1'b1;
         default: ;
      endcase
      if (w_wr_req) begin
         w_state_next = WRITE;
      end else if (w_rd_req) begin
         w_state_next = READ;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_idata <= '0;
         r_odata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_req) begin
            r_addr  <= bus.ADDR;
            r_idata <= bus.IDATA;
         end
         if (w_mem_re) begin
            r_odata <= r_mem[r_addr];
         end
      end
   end

   // Array contents are deliberately not reset; a reset clears r_state, so no commit follows.
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         r_mem[r_addr] <= r_idata;
      end
   end

   assign bus.ODATA = r_odata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table-driven request stream plus reset sequences.
module tb_mem_ctrl;
   localparam int AW = 16;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   // exp = ODATA observed at the falling edge where this vector is applied.
   typedef struct {
      logic          ce;
      logic          csb;
      logic          web;
      logic          oeb;
      logic [AW-1:0] addr;
      logic [DW-1:0] idata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] dat(int k);
      return 8'(17 * k + 5);
   endfunction

   task automatic add(input logic ce, input logic csb, input logic web, input logic oeb,
                      input logic [AW-1:0] addr, input logic [DW-1:0] idata,
                      input logic [DW-1:0] exp);
      vec_t v;
      v.ce = ce; v.csb = csb; v.web = web; v.oeb = oeb;
      v.addr = addr; v.idata = idata; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
      add(1'b1, 1'b0, 1'b0, 1'b1, a, d, e);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
      add(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, e);
   endtask

   task automatic nop(input logic [DW-1:0] e);
      add(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, e);
   endtask

   task automatic drive(input logic ce, input logic csb, input logic web, input logic oeb,
                        input logic [AW-1:0] addr, input logic [DW-1:0] idata);
      bus.CE = ce; bus.CSB = csb; bus.WEB = web; bus.OEB = oeb;
      bus.ADDR = addr; bus.IDATA = idata;
   endtask

   task automatic idle();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: ODATA=%02h expected %02h", name, act, exp);
      end else begin
         $display("ok   %s: ODATA=%02h", name, act);
      end
   endtask

   initial begin
      idle();
      repeat (3) @(negedge clk);
      chk("reset_initial", bus.ODATA, 8'h00);
      rst = 1'b0;

      // Seed 0x0040 so a blocked write during reset is detectable later.
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 8'h12);
      @(negedge clk); idle();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'h0040, 8'hEE);
         @(negedge clk);
         chk($sformatf("reset_hold%0d", i), bus.ODATA, 8'h00);
      end
      idle();
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         wr(16'(k), dat(k), 8'h00);
         nop(8'h00);
      end
      repeat (5) nop(8'h00);
      for (int k = 0; k < 10; k++) begin
         rd(16'(k), (k == 0) ? 8'h00 : dat(k - 1));
         nop((k == 0) ? 8'h00 : dat(k - 1));
      end
      nop(dat(9)); nop(dat(9));
      // Qualifier gating: CSB=1 and CE=0 writes must be ignored.
      wr(16'h0010, 8'hA5, dat(9)); nop(dat(9));
      add(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h3C, dat(9));
      add(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 8'h3C, dat(9));
      rd(16'h0010, dat(9)); nop(dat(9)); nop(8'hA5);
      // WEB has priority over OEB.
      add(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 8'h5A, 8'hA5);
      nop(8'hA5); nop(8'hA5);
      rd(16'h0020, 8'hA5); nop(8'hA5); nop(8'h5A);
      // Selected request with WEB=1, OEB=1 is a no-op.
      add(1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 8'hFF, 8'h5A);
      nop(8'h5A); nop(8'h5A);
      // Write then immediate read at the top address.
      wr(16'hFFFF, 8'h77, 8'h5A); rd(16'hFFFF, 8'h5A); nop(8'h5A); nop(8'h77);
      // Back-to-back reads stream out in order.
      rd(16'h0010, 8'h77); rd(16'h0020, 8'h77); nop(8'hA5); nop(8'h5A);
      // The write held during reset must not have landed.
      rd(16'h0040, 8'h5A); nop(8'h5A); nop(8'h12);

      foreach (vecs[i]) begin
         @(negedge clk);
         chk($sformatf("vec%0d", i), bus.ODATA, vecs[i].exp);
         drive(vecs[i].ce, vecs[i].csb, vecs[i].web, vecs[i].oeb, vecs[i].addr, vecs[i].idata);
      end

      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 8'h99);
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 8'h00);
      @(negedge clk); idle();
      @(negedge clk);
      chk("pre_reset_read", bus.ODATA, 8'h99);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 8'h11);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("reset_async", bus.ODATA, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 8'h00);
      @(negedge clk); idle();
      chk("post_reset_idle", bus.ODATA, 8'h00);
      @(negedge clk);
      chk("reset_discard", bus.ODATA, 8'h99);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
